// File: rtl/scs8hd_clkgate_ctrl.sv
// Enable controller for a latch-based clock-gating cell: wake, idle count, sleep handshake.
// Latency: GATE one cycle after a sampled wake request, WAKE_ACK WAKE_LAT cycles after that.
// Backpressure: sleep waits indefinitely for SLEEP_ACK; wake or busy in DRAIN aborts the sleep.
module scs8hd_clkgate_ctrl #(
   parameter int IDLE_HOLD = 8,
   parameter int WAKE_LAT  = 2
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       WAKE_REQ,
   input  logic       BUSY,
   input  logic       SLEEP_ACK,
   input  logic       FORCE_ON,
   output logic       GATE,
   output logic       WAKE_ACK,
   output logic       SLEEP_REQ,
   output logic [1:0] STATE
);

   typedef enum logic [1:0] {
      S_OFF    = 2'b00,
      S_WAKING = 2'b01,
      S_ON     = 2'b10,
      S_DRAIN  = 2'b11
   } state_t;

   localparam logic [3:0] WAKE_LAST = 4'(WAKE_LAT - 1);
   localparam logic [7:0] IDLE_LAST = 8'(IDLE_HOLD - 1);
   localparam logic [7:0] IDLE_MAX  = 8'(IDLE_HOLD);

   state_t     state;
   logic       gate_q;
   logic       wake_ack_q;
   logic       sleep_req_q;
   logic [3:0] wake_cnt;
   logic [7:0] idle_cnt;
   logic       idle;

   // A cycle is idle only when nobody wants the clock and the domain reports no activity.
   assign idle = !WAKE_REQ && !BUSY;

   // Single registered FSM; every output except GATE comes straight from a flop.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= S_OFF;
         gate_q      <= 1'b0;
         wake_ack_q  <= 1'b0;
         sleep_req_q <= 1'b0;
         wake_cnt    <= 4'd0;
         idle_cnt    <= 8'd0;
      end else begin
         case (state)
            S_OFF: begin
               gate_q      <= 1'b0;
               wake_ack_q  <= 1'b0;
               sleep_req_q <= 1'b0;
               if (WAKE_REQ) begin
                  state    <= S_WAKING;
                  gate_q   <= 1'b1;
                  wake_cnt <= 4'd0;
                  idle_cnt <= 8'd0;
               end
            end
            S_WAKING: begin
               // Wake is committed once started; WAKE_REQ is not looked at here.
               gate_q <= 1'b1;
               if (wake_cnt == WAKE_LAST) begin
                  state      <= S_ON;
                  wake_ack_q <= 1'b1;
                  wake_cnt   <= 4'd0;
                  idle_cnt   <= 8'd0;
               end else begin
                  wake_cnt <= wake_cnt + 4'd1;
               end
            end
            S_ON: begin
               gate_q <= 1'b1;
               if (idle) begin
                  if (idle_cnt == IDLE_LAST) begin
                     state       <= S_DRAIN;
                     wake_ack_q  <= 1'b0;
                     sleep_req_q <= 1'b1;
                     idle_cnt    <= 8'd0;
                  end else if (idle_cnt < IDLE_MAX) begin
                     idle_cnt <= idle_cnt + 8'd1;
                  end
               end else begin
                  idle_cnt <= 8'd0;
               end
            end
            S_DRAIN: begin
               // A new wake or activity beats a simultaneous acknowledge; gate stays high.
               if (WAKE_REQ || BUSY) begin
                  state       <= S_ON;
                  sleep_req_q <= 1'b0;
                  wake_ack_q  <= 1'b1;
                  idle_cnt    <= 8'd0;
               end else if (SLEEP_ACK) begin
                  state       <= S_OFF;
                  gate_q      <= 1'b0;
                  sleep_req_q <= 1'b0;
                  idle_cnt    <= 8'd0;
               end
            end
            default: begin
               state <= S_OFF;
            end
         endcase
      end
   end

   // The override is a single OR after the flop so scan can open the gate at any time.
   assign GATE      = gate_q | FORCE_ON;
   assign WAKE_ACK  = wake_ack_q;
   assign SLEEP_REQ = sleep_req_q;
   assign STATE     = state;

endmodule
